// File: rtl/serial_cmd_seq.sv
// Word-level UART debug command sequencer: opcode, optional address/data words, each echoed,
// then a controller request/complete handshake, a reply word and an optional status word.
module serial_cmd_seq #(
  parameter int unsigned         DATA_W         = 32,
  parameter int unsigned         CMD_W          = 4,
  parameter logic [2**CMD_W-1:0] ADDR_MASK      = '1,
  parameter logic [2**CMD_W-1:0] DATA_MASK      = '1,
  parameter int unsigned         TIMEOUT_CYCLES = 5_000_000,
  parameter bit                  STATUS_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_word,
  input  logic              tx_idle,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_word,
  input  logic              ctrlr_busy,
  input  logic [DATA_W-1:0] d_rd,
  input  logic              error,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] d_in,
  output logic              out_valid,
  output logic              timeout_err,
  output logic              rx_overrun
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [3:0] {
    WAIT_CMD,
    ECHO_CMD,
    WAIT_ADDR,
    ECHO_ADDR,
    WAIT_DATA,
    ECHO_DATA,
    ISSUE,
    EXEC,
    REPLY,
    STATUS
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            tx_done;
  logic            to_hit;
  logic            rx_accept_state;

  // A transmit is finished only once the strobe has dropped and the transmitter is idle again.
  assign tx_done = tx_idle && !tx_start;
  assign to_hit  = TO_EN && (to_cnt == TO_LAST);
  assign rx_accept_state = (state == WAIT_CMD) || (state == WAIT_ADDR) || (state == WAIT_DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_CMD;
      to_cnt      <= '0;
      err_q       <= 1'b0;
      tx_start    <= 1'b0;
      tx_word     <= '0;
      cmd         <= '0;
      addr        <= '0;
      d_in        <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      rx_overrun  <= rx_ready && !rx_accept_state;
      to_cnt      <= '0;

      case (state)
        WAIT_CMD: begin
          if (rx_ready) begin
            cmd      <= rx_word[CMD_W-1:0];
            addr     <= '0;
            d_in     <= '0;
            tx_word  <= DATA_W'(rx_word[CMD_W-1:0]);
            tx_start <= 1'b1;
            state    <= ECHO_CMD;
          end
        end
        ECHO_CMD: begin
          if (tx_done) begin
            if (ADDR_MASK[cmd]) begin
              state <= WAIT_ADDR;
            end else if (DATA_MASK[cmd]) begin
              state <= WAIT_DATA;
            end else begin
              state     <= ISSUE;
              out_valid <= 1'b1;
            end
          end
        end
        WAIT_ADDR: begin
          if (rx_ready) begin
            addr     <= rx_word;
            tx_word  <= rx_word;
            tx_start <= 1'b1;
            state    <= ECHO_ADDR;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            state       <= WAIT_CMD;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ECHO_ADDR: begin
          if (tx_done) begin
            if (DATA_MASK[cmd]) begin
              state <= WAIT_DATA;
            end else begin
              state     <= ISSUE;
              out_valid <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (rx_ready) begin
            d_in     <= rx_word;
            tx_word  <= rx_word;
            tx_start <= 1'b1;
            state    <= ECHO_DATA;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            state       <= WAIT_CMD;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ECHO_DATA: begin
          if (tx_done) begin
            state     <= ISSUE;
            out_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (ctrlr_busy) begin
            out_valid <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Read data and error are only meaningful on the cycle busy is seen low.
          if (!ctrlr_busy) begin
            tx_word  <= d_rd;
            err_q    <= error;
            tx_start <= 1'b1;
            state    <= REPLY;
          end
        end
        REPLY: begin
          if (tx_done) begin
            if (STATUS_EN) begin
              tx_word  <= DATA_W'(err_q);
              tx_start <= 1'b1;
              state    <= STATUS;
            end else begin
              state <= WAIT_CMD;
            end
          end
        end
        STATUS: begin
          if (tx_done) begin
            state <= WAIT_CMD;
          end
        end
        default: state <= WAIT_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_seq.sv
// Scoreboard bench for serial_cmd_seq: expected tx words and controller requests are queued by
// the stimulus and checked by an independent monitor whenever the DUT strobes them.
module tb_serial_cmd_seq;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 4;

  typedef struct packed {
    logic [CMD_W-1:0]  c;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] d;
  } req_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_ready = 1'b0;
  logic [DATA_W-1:0] rx_word = '0;
  logic              tx_idle;
  logic              tx_start;
  logic [DATA_W-1:0] tx_word;
  logic              ctrlr_busy = 1'b0;
  logic [DATA_W-1:0] d_rd = '0;
  logic              error = 1'b0;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] d_in;
  logic              out_valid;
  logic              timeout_err;
  logic              rx_overrun;

  logic [DATA_W-1:0] sb_q[$];
  req_t              req_q[$];
  int                checks = 0;
  int                errors = 0;
  int                to_count = 0;
  int                ovr_count = 0;
  int                ov_rises = 0;
  logic              ov_prev = 1'b0;
  int                tx_cnt = 0;

  serial_cmd_seq #(
    .DATA_W(DATA_W),
    .CMD_W(CMD_W),
    .ADDR_MASK(16'hFFDF),
    .DATA_MASK(16'hFFDB),
    .TIMEOUT_CYCLES(100),
    .STATUS_EN(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_ready(rx_ready),
    .rx_word(rx_word),
    .tx_idle(tx_idle),
    .tx_start(tx_start),
    .tx_word(tx_word),
    .ctrlr_busy(ctrlr_busy),
    .d_rd(d_rd),
    .error(error),
    .cmd(cmd),
    .addr(addr),
    .d_in(d_in),
    .out_valid(out_valid),
    .timeout_err(timeout_err),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for three cycles after each strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_idle <= 1'b1;
      tx_cnt  <= 0;
    end else if (tx_start) begin
      tx_idle <= 1'b0;
      tx_cnt  <= 3;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_idle <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every DUT output event.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h expected no transmit", tx_word);
        end else begin
          chk("tx_word", 128'(tx_word), 128'(sb_q.pop_front()));
        end
      end
      if (out_valid && !ov_prev) begin
        ov_rises++;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got cmd %0h addr %0h d_in %0h expected none", cmd, addr, d_in);
        end else begin
          chk("request", 128'({cmd, addr, d_in}), 128'(req_q.pop_front()));
        end
      end
      ov_prev = out_valid;
      if (timeout_err) to_count++;
      if (rx_overrun) ovr_count++;
    end else begin
      ov_prev = 1'b0;
    end
  end

  task automatic send(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] echo);
    sb_q.push_back(echo);
    rx_word  = w;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("rx_to_tx_latency", 128'(tx_start), 128'(1));
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic run_ctrl(input int busy_cyc, input logic [DATA_W-1:0] rd, input logic err);
    int n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL ctrl_wait: got out_valid 0 expected 1 within 300 cycles");
      return;
    end
    sb_q.push_back(rd);
    sb_q.push_back(DATA_W'(err));
    ctrlr_busy = 1'b1;
    repeat (busy_cyc) @(posedge clk);
    #1;
    chk("out_valid_cleared", 128'(out_valid), 128'(0));
    ctrlr_busy = 1'b0;
    d_rd       = rd;
    error      = err;
    @(posedge clk);
    #1;
    chk("busy_to_reply_latency", 128'(tx_start), 128'(1));
    d_rd  = '0;
    error = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    int to_before;
    int ov_before;
    req_t r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", 128'(tx_start), 128'(0));
    chk("rst_tx_word", 128'(tx_word), 128'(0));
    chk("rst_cmd", 128'(cmd), 128'(0));
    chk("rst_addr", 128'(addr), 128'(0));
    chk("rst_d_in", 128'(d_in), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_timeout_err", 128'(timeout_err), 128'(0));
    chk("rst_rx_overrun", 128'(rx_overrun), 128'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full command with address and data.
    r = '{c: 4'h3, a: 32'h1000_0004, d: 32'hDEAD_BEEF};
    req_q.push_back(r);
    send(32'h3, 32'h3);
    send(32'h1000_0004, 32'h1000_0004);
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_ctrl(5, 32'h1234_5678, 1'b0);

    // Address only.
    r = '{c: 4'h2, a: 32'h20, d: 32'h0};
    req_q.push_back(r);
    send(32'h2, 32'h2);
    send(32'h20, 32'h20);
    run_ctrl(3, 32'h0000_A5A5, 1'b0);

    // No arguments, controller error reported in status word; upper rx bits ignored.
    r = '{c: 4'h5, a: 32'h0, d: 32'h0};
    req_q.push_back(r);
    send(32'hFFFF_FFF5, 32'h5);
    run_ctrl(2, 32'h0000_0077, 1'b1);

    // Silence after opcode: timeout lands on the 100th wait cycle.
    to_before = to_count;
    ov_before = ov_rises;
    sb_q.push_back(32'h3);
    rx_word  = 32'h3;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    hit = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (timeout_err && hit == 0) hit = i;
    end
    chk("timeout_cycle", 128'(hit), 128'(105));
    chk("timeout_pulses", 128'(to_count - to_before), 128'(1));
    chk("timeout_no_request", 128'(ov_rises - ov_before), 128'(0));

    // Word arriving on the expiry cycle wins over the timeout.
    to_before = to_count;
    r = '{c: 4'h3, a: 32'h100, d: 32'h200};
    req_q.push_back(r);
    sb_q.push_back(32'h3);
    rx_word  = 32'h3;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (104) @(posedge clk);
    #1;
    sb_q.push_back(32'h100);
    rx_word  = 32'h100;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("expiry_accept_tx", 128'(tx_start), 128'(1));
    chk("expiry_no_timeout", 128'(timeout_err), 128'(0));
    repeat (12) @(posedge clk);
    #1;
    send(32'h200, 32'h200);
    run_ctrl(1, 32'h0000_0F0F, 1'b0);
    chk("expiry_timeouts", 128'(to_count - to_before), 128'(0));

    // Word arriving during the opcode echo is discarded.
    chk("overrun_none_yet", 128'(ovr_count), 128'(0));
    r = '{c: 4'h1, a: 32'h44, d: 32'h55};
    req_q.push_back(r);
    sb_q.push_back(32'h1);
    rx_word  = 32'h1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_word = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("overrun_pulse", 128'(rx_overrun), 128'(1));
    repeat (12) @(posedge clk);
    #1;
    send(32'h44, 32'h44);
    send(32'h55, 32'h55);
    run_ctrl(2, 32'h0000_0099, 1'b0);
    chk("overrun_count", 128'(ovr_count), 128'(1));

    // Reset while the controller is executing.
    r = '{c: 4'h3, a: 32'hA, d: 32'hB};
    req_q.push_back(r);
    send(32'h3, 32'h3);
    send(32'hA, 32'hA);
    send(32'hB, 32'hB);
    hit = 0;
    while (!out_valid && hit < 300) begin
      @(posedge clk);
      #1 hit++;
    end
    chk("pre_reset_request", 128'(out_valid), 128'(1));
    ctrlr_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_cmd", 128'(cmd), 128'(0));
    chk("async_rst_addr", 128'(addr), 128'(0));
    chk("async_rst_d_in", 128'(d_in), 128'(0));
    chk("async_rst_tx_word", 128'(tx_word), 128'(0));
    chk("async_rst_out_valid", 128'(out_valid), 128'(0));
    chk("async_rst_tx_start", 128'(tx_start), 128'(0));
    chk("pre_reset_sb_empty", 128'(sb_q.size()), 128'(0));
    ctrlr_busy = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    r = '{c: 4'h1, a: 32'h60, d: 32'h61};
    req_q.push_back(r);
    send(32'h1, 32'h1);
    send(32'h60, 32'h60);
    send(32'h61, 32'h61);
    run_ctrl(2, 32'hCAFE_0001, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("end_sb_empty", 128'(sb_q.size()), 128'(0));
    chk("end_req_empty", 128'(req_q.size()), 128'(0));
    chk("end_timeouts", 128'(to_count), 128'(1));
    chk("end_overruns", 128'(ovr_count), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_cmd_seq.md
Name: serial_cmd_seq

Overview:
Parametrised word-level command sequencer for the UART debug path; successor to the fixed cmd/addr/data serial decoder. Sits between the uart_rx_word/uart_tx_word pair and the debug controller. Per-opcode argument masks select whether address and/or data words follow the command. Adds an inter-word receive timeout, receive-overrun flagging, a clean accept/complete handshake with the controller, and an optional trailing status word.

Parameters:
DATA_W, 32, width of rx/tx words, addr, d_in, d_rd
CMD_W, 4, opcode width, taken from rx_word[CMD_W-1:0]
ADDR_MASK, {2**CMD_W{1'b1}}, bit n set means opcode n is followed by an address word
DATA_MASK, {2**CMD_W{1'b1}}, bit n set means opcode n is followed by a data word (after address if both)
TIMEOUT_CYCLES, 5_000_000, max idle cycles in WAIT_ADDR/WAIT_DATA; 0 disables timeout
STATUS_EN, 1, 1 means a status word is sent after the reply word

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_ready  in  1  one-cycle pulse, rx_word valid
rx_word  in  DATA_W  received word
tx_idle  in  1  transmitter idle
tx_start  out  1  one-cycle transmit strobe
tx_word  out  DATA_W  word to transmit, stable from tx_start until tx_idle returns
ctrlr_busy  in  1  controller executing
d_rd  in  DATA_W  controller read data, valid when ctrlr_busy falls
error  in  1  controller error, sampled with d_rd
cmd  out  CMD_W  latched opcode
addr  out  DATA_W  latched address (0 if opcode takes none)
d_in  out  DATA_W  latched data (0 if opcode takes none)
out_valid  out  1  command request to controller
timeout_err  out  1  one-cycle pulse on argument timeout
rx_overrun  out  1  one-cycle pulse when rx_ready arrives in a non-WAIT state

Behaviour:
- Reset (async, any state): state WAIT_CMD; every output 0; timeout counter 0; latched error 0.
- States: WAIT_CMD, ECHO_CMD, WAIT_ADDR, ECHO_ADDR, WAIT_DATA, ECHO_DATA, ISSUE, EXEC, REPLY, STATUS.
- WAIT_CMD: on rx_ready latch cmd, clear addr and d_in, tx_word <= zero-extended opcode, tx_start <= 1, go ECHO_CMD.
- ECHO_x: tx_start forced 0 next cycle; leave only when tx_idle && !tx_start. Next state after ECHO_CMD: WAIT_ADDR if ADDR_MASK[cmd], else WAIT_DATA if DATA_MASK[cmd], else ISSUE. After ECHO_ADDR: WAIT_DATA if DATA_MASK[cmd], else ISSUE. After ECHO_DATA: ISSUE.
- WAIT_ADDR/WAIT_DATA: on rx_ready latch addr/d_in, echo full word, go ECHO_ADDR/ECHO_DATA.
- Timeout: counter cleared on entry to WAIT_ADDR/WAIT_DATA and on each cycle outside them; increments each waiting cycle. When count reaches TIMEOUT_CYCLES-1 with no rx_ready: pulse timeout_err, go WAIT_CMD, out_valid stays 0. rx_ready in the expiry cycle takes priority (no timeout). Counter width $clog2(TIMEOUT_CYCLES+1). No timeout in WAIT_CMD.
- ISSUE: out_valid = 1, held until the first cycle ctrlr_busy = 1; out_valid clears the next cycle; go EXEC. No timeout.
- EXEC: on ctrlr_busy = 0, capture d_rd into tx_word, latch error, pulse tx_start, go REPLY.
- REPLY: on tx_idle && !tx_start: if STATUS_EN, tx_word <= {zeros, latched error}, pulse tx_start, go STATUS; else go WAIT_CMD.
- STATUS: on tx_idle && !tx_start go WAIT_CMD.
- rx_ready in ECHO_x/ISSUE/EXEC/REPLY/STATUS: word discarded, rx_overrun pulses 1 cycle, state unaffected.
- cmd/addr/d_in stable from ISSUE entry until next WAIT_CMD capture.
- Latency: rx_ready to tx_start = 1 cycle; ctrlr_busy falling to reply tx_start = 1 cycle.

Test Plan:
- Defaults, rx 0x3, 0x1000_0004, 0xDEAD_BEEF -> echoes 0x3, 0x1000_0004, 0xDEAD_BEEF; out_valid with cmd=3, addr=0x1000_0004, d_in=0xDEAD_BEEF; busy 5 cycles, d_rd=0x1234_5678, error=0 -> tx 0x1234_5678 then status 0x0.
- ADDR_MASK bit 2 set, DATA_MASK bit 2 clear, cmd 2 + addr 0x20 -> no data wait; d_in=0; out_valid after addr echo.
- Both masks clear for cmd 5 -> echo 0x5, direct ISSUE with addr=0, d_in=0; error=1 -> status word 0x1.
- TIMEOUT_CYCLES=100, cmd 3 then silence -> timeout_err pulses once at 100th wait cycle, state WAIT_CMD, out_valid never set; rx_ready on the expiry cycle -> accepted, no timeout_err.
- rx_ready during ECHO_CMD -> rx_overrun pulse, sequence completes normally.
- reset asserted during EXEC -> all outputs 0 immediately; next rx 0x1 starts a fresh sequence.
